memory_access: RTL and testbench
================================

# memory_access

Memory stage of the multi-cycle core, directly downstream of `execute`. It captures the execute results on a start pulse and performs at most one data-memory access over a request/acknowledge handshake. For stores it builds byte strobes and replicated write data. For loads it extracts the addressed lane and applies sign or zero extension. It then presents the write-back value, destination and write enable with a one-cycle `done` pulse.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; sample execute outputs. Sampled only in IDLE.
- `instr` in `instructions` (def.sv struct): decoded flags; only lb, lh, lw, lbu, lhu, sb, sh, sw are used.
- `result` in 32: execute result; the byte address when a memory flag is set, otherwise the pass-through value.
- `rs2_v` in 32: store source data.
- `mem_read_enabled`, `mem_write_enabled` in 1 each: from execute.
- `reg_write_enabled` in 1, `reg_write_dest` in 5: from execute.
- `mem_req` out 1: access request; held high until acknowledged.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wstrb` out 4: byte enables, bit i = byte lane i (little-endian).
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data; valid in the cycle `mem_ack`=1.
- `mem_ack` in 1: completes the access.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `wb_value` out 32, `wb_enabled` out 1, `wb_dest` out 5: write-back outputs, valid while `done`=1 and held afterwards.
- `misaligned` out 1: valid with `done`; the access was rejected.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE + start:** latch `result` as `addr`, plus `rs2_v`, `instr`, the enables and `reg_write_dest`.
  - If write is set, write wins (read+write both set is illegal upstream; write is the defined priority). Otherwise read, otherwise none.
  - **No access:** go to DONE. `wb_value`=`result`, `wb_enabled`=`reg_write_enabled`.
  - **Access, aligned:** go to REQ. `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb` and `mem_wdata` are registered on this edge.
  - **Access, misaligned:** go to DONE with `misaligned`=1 and `wb_enabled`=0. No request is issued.
  - Alignment rules (a=`addr[1:0]`): lw/sw need a==0; lh/lhu/sh need a[0]==0; byte accesses are always aligned.
- **Store encoding:**
  - sb: `wstrb`=`4'b0001<<a`, `wdata`=`{4{rs2_v[7:0]}}`.
  - sh: `wstrb`=`4'b0011<<a`, `wdata`=`{2{rs2_v[15:0]}}`.
  - sw: `wstrb`=`4'b1111`, `wdata`=`rs2_v`.
  - Loads drive `wstrb`=0.
- **REQ:** outputs held stable until `mem_ack`. On the edge where req&&ack: drop `mem_req`, go to DONE.
  - Load: the lane is selected from `mem_rdata` by a (halfword lane = `a[1]`). lb/lh sign-extend, lbu/lhu zero-extend, lw takes the whole word. `wb_enabled`=`reg_write_enabled`.
  - Store: `wb_enabled`=0; `wb_value`=`addr`.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE. `mem_ack` is ignored outside REQ.
- No timeout; REQ waits indefinitely.

## Timing
- **Reset values:** all outputs 0; state IDLE. Asynchronous: `mem_req` drops immediately on `rstn` low, including mid-REQ. The pending access is abandoned.
- **No access or misaligned:** `start` at edge 0 → `done` high in cycle 1 → IDLE at edge 2. Latency 1.
- **Memory access:** `start` at edge 0 → `mem_req` high from cycle 1. If ack arrives in cycle k≥1, `done` is high in cycle k+1. Minimum latency 2 (ack in the first REQ cycle).
- **Back-to-back:** a new `start` is accepted in the cycle after `done` (IDLE). A `start` coincident with `done` is ignored.
- `wb_*` and `misaligned` change only on entry to DONE.

## Test plan
- Pass-through: `start`, no memory flags, `result`=0x1234_5678, dest=5, `reg_write_enabled`=1 → no `mem_req`; cycle 1: `done`=1, `wb_value`=0x12345678, `wb_dest`=5, `wb_enabled`=1.
- lb sign-extend: `addr`=0x1003, `mem_rdata`=0x80FF_FFFF, ack after 3 wait cycles → `mem_addr`=0x1000, `wstrb`=0, `req` high 4 cycles, `wb_value`=0xFFFF_FF80. Repeat with lbu → 0x0000_0080.
- sh at `addr`=0x2002, `rs2_v`=0xDEAD_BEEF, ack in the first cycle → `mem_we`=1, `wstrb`=1100, `wdata`=0xBEEF_BEEF, `wb_enabled`=0, `done` at cycle 2.
- Misaligned lw at `addr`=0x3001 → `mem_req` never asserted; cycle 1: `done`=1, `misaligned`=1, `wb_enabled`=0.
- Reset mid-REQ: drop `rstn` during a pending sw → `mem_req`, `busy`, `done` are 0 immediately. After release, a fresh lw at `addr`=0x0, `rdata`=0xCAFEBABE → `wb_value`=0xCAFEBABE.
- Protocol robustness:
  - a spurious `mem_ack` in IDLE is ignored;
  - a `start` pulse in REQ is ignored and the original access completes;
  - read+write both set at `start` → a write is issued.

Source files
------------

// File: rtl/memory_access_if.sv
// Decoded-instruction flags shared with execute, and the data-memory request bus.
// The memory stage is the master; the data memory (or its model) is the slave.
`timescale 1ns/1ps

package memory_access_pkg;
    typedef struct packed {
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
        logic sb;
        logic sh;
        logic sw;
    } instructions;
endpackage

// Handshake: the master raises mem_req with mem_we/addr/wstrb/wdata stable and keeps
// them stable until a cycle with mem_req && mem_ack; that cycle completes the transfer,
// and for reads mem_rdata is valid only in that cycle. mem_ack without mem_req means nothing.
interface memory_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/memory_access.sv
// Memory stage: latches execute results on start, performs at most one load/store
// over the request bus, and presents write-back data with a one-cycle done pulse.
`timescale 1ns/1ps

module memory_access
    import memory_access_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  instructions       instr,
    input  logic [31:0]       result,
    input  logic [31:0]       rs2_v,
    input  logic              mem_read_enabled,
    input  logic              mem_write_enabled,
    input  logic              reg_write_enabled,
    input  logic [4:0]        reg_write_dest,
    memory_access_if.master   mem,
    output logic              busy,
    output logic              done,
    output logic [31:0]       wb_value,
    output logic              wb_enabled,
    output logic [4:0]        wb_dest,
    output logic              misaligned,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_next;
    logic [1:0]  a;
    logic        access, aligned;
    logic [3:0]  wstrb_next;
    logic [31:0] wdata_next;

    logic [31:0] addr_q;
    logic        reg_we_q;
    logic [4:0]  dest_q;
    logic        ld_byte_q, ld_half_q, ld_signed_q;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_value;

    assign a         = result[1:0];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        access  = mem_write_enabled | mem_read_enabled;
        aligned = 1'b1;
        if (instr.lw || instr.sw)                    aligned = (a == 2'b00);
        else if (instr.lh || instr.lhu || instr.sh)  aligned = ~a[0];

        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (access && aligned) ? REQ : DONE;
            REQ:     if (mem.mem_req && mem.mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Store lanes: narrow data is replicated so every strobed lane carries the value.
    always_comb begin
        wstrb_next = 4'b0000;
        wdata_next = rs2_v;
        if (mem_write_enabled) begin
            if (instr.sb) begin
                wstrb_next = 4'b0001 << a;
                wdata_next = {4{rs2_v[7:0]}};
            end else if (instr.sh) begin
                wstrb_next = 4'b0011 << a;
                wdata_next = {2{rs2_v[15:0]}};
            end else if (instr.sw) begin
                wstrb_next = 4'b1111;
            end
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = mem.mem_rdata[7:0];
            2'd1:    lane_b = mem.mem_rdata[15:8];
            2'd2:    lane_b = mem.mem_rdata[23:16];
            default: lane_b = mem.mem_rdata[31:24];
        endcase
        lane_h     = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        load_value = mem.mem_rdata;
        if (ld_byte_q)      load_value = {{24{ld_signed_q & lane_b[7]}}, lane_b};
        else if (ld_half_q) load_value = {{16{ld_signed_q & lane_h[15]}}, lane_h};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q        <= '0;
            reg_we_q      <= 1'b0;
            dest_q        <= '0;
            ld_byte_q     <= 1'b0;
            ld_half_q     <= 1'b0;
            ld_signed_q   <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wstrb <= '0;
            mem.mem_wdata <= '0;
            wb_value      <= '0;
            wb_enabled    <= 1'b0;
            wb_dest       <= '0;
            misaligned    <= 1'b0;
        end else if (state == IDLE && start) begin
            addr_q      <= result;
            reg_we_q    <= reg_write_enabled;
            dest_q      <= reg_write_dest;
            ld_byte_q   <= instr.lb | instr.lbu;
            ld_half_q   <= instr.lh | instr.lhu;
            ld_signed_q <= instr.lb | instr.lh;
            if (access && aligned) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= mem_write_enabled;
                mem.mem_addr  <= {result[31:2], 2'b00};
                mem.mem_wstrb <= wstrb_next;
                mem.mem_wdata <= wdata_next;
            end else begin
                // Pass-through, or a rejected misaligned access that never reaches memory.
                wb_value   <= result;
                wb_enabled <= access ? 1'b0 : reg_write_enabled;
                wb_dest    <= reg_write_dest;
                misaligned <= access;
            end
        end else if (state == REQ && mem.mem_req && mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            wb_dest     <= dest_q;
            misaligned  <= 1'b0;
            if (mem.mem_we) begin
                wb_value   <= addr_q;
                wb_enabled <= 1'b0;
            end else begin
                wb_value   <= load_value;
                wb_enabled <= reg_we_q;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: pass-through, loads, stores, misalignment,
// asynchronous reset mid-request and handshake robustness.
`timescale 1ns/1ps

module tb_memory_access;
    import memory_access_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    instructions instr = '0;
    logic [31:0] result = '0;
    logic [31:0] rs2_v = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic        rwe = 1'b0;
    logic [4:0]  dest = '0;
    logic        busy, done, wb_enabled, misaligned;
    logic [31:0] wb_value;
    logic [4:0]  wb_dest;
    logic [1:0]  dbg_state;
    int          n_cmp = 0;
    int          n_fail = 0;

    memory_access_if bus();

    always #5 clk = ~clk;

    memory_access dut (
        .clk               (clk),
        .rstn              (rstn),
        .start             (start),
        .instr             (instr),
        .result            (result),
        .rs2_v             (rs2_v),
        .mem_read_enabled  (rd_en),
        .mem_write_enabled (wr_en),
        .reg_write_enabled (rwe),
        .reg_write_dest    (dest),
        .mem               (bus.master),
        .busy              (busy),
        .done              (done),
        .wb_value          (wb_value),
        .wb_enabled        (wb_enabled),
        .wb_dest           (wb_dest),
        .misaligned        (misaligned),
        .dbg_state         (dbg_state)
    );

    // Drives one start pulse; returns #1 into the first cycle after the accepting edge.
    task automatic drive_start(input instructions ins, input logic [31:0] res,
                               input logic [31:0] rs2, input logic rd, input logic wr,
                               input logic we, input logic [4:0] d);
        instr  = ins;
        result = res;
        rs2_v  = rs2;
        rd_en  = rd;
        wr_en  = wr;
        rwe    = we;
        dest   = d;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", bus.mem_req); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", done); end
        n_cmp++; if (wb_value !== 32'h0) begin n_fail++; $display("FAIL rst_wb_value: got %h want 0", wb_value); end
        n_cmp++; if (bus.mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL rst_wstrb: got %b want 0000", bus.mem_wstrb); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        rstn = 1'b1;
        next_cycle();
    endtask

    task automatic test_pass_through();
        drive_start('0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5);
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL pt_req: got %0b want 0", bus.mem_req); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL pt_done: got %0b want 1", done); end
        n_cmp++; if (wb_value !== 32'h1234_5678) begin n_fail++; $display("FAIL pt_value: got %h want 12345678", wb_value); end
        n_cmp++; if (wb_dest !== 5'd5) begin n_fail++; $display("FAIL pt_dest: got %0d want 5", wb_dest); end
        n_cmp++; if (wb_enabled !== 1'b1) begin n_fail++; $display("FAIL pt_wb_en: got %0b want 1", wb_enabled); end
        next_cycle();
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL pt_idle: got done=%0b busy=%0b want 0 0", done, busy); end
        n_cmp++; if (wb_value !== 32'h1234_5678) begin n_fail++; $display("FAIL pt_hold: got %h want 12345678", wb_value); end
    endtask

    task automatic test_load_byte(input logic unsigned_ld, input logic [31:0] exp);
        instructions ins;
        int req_cycles;
        ins = '0;
        if (unsigned_ld) ins.lbu = 1'b1; else ins.lb = 1'b1;
        req_cycles = 0;
        drive_start(ins, 32'h0000_1003, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9);
        n_cmp++; if (bus.mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL lb_addr: got %h want 00001000", bus.mem_addr); end
        n_cmp++; if (bus.mem_wstrb !== 4'b0000 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL lb_wstrb_we: got %b/%0b want 0000/0", bus.mem_wstrb, bus.mem_we); end
        for (int i = 0; i < 3; i++) begin
            if (bus.mem_req === 1'b1) req_cycles++;
            next_cycle();
        end
        if (bus.mem_req === 1'b1) req_cycles++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h80FF_FFFF;
        next_cycle();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        n_cmp++; if (req_cycles != 4) begin n_fail++; $display("FAIL lb_req_cycles: got %0d want 4", req_cycles); end
        n_cmp++; if (done !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL lb_done: got done=%0b req=%0b want 1 0", done, bus.mem_req); end
        n_cmp++; if (wb_value !== exp) begin n_fail++; $display("FAIL lb_value: got %h want %h", wb_value, exp); end
        n_cmp++; if (wb_enabled !== 1'b1 || wb_dest !== 5'd9) begin n_fail++; $display("FAIL lb_wb: got en=%0b dest=%0d want 1 9", wb_enabled, wb_dest); end
        next_cycle();
    endtask

    task automatic test_store_half();
        instructions ins;
        ins = '0;
        ins.sh = 1'b1;
        drive_start(ins, 32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 5'd3);
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL sh_req_we: got %0b/%0b want 1/1", bus.mem_req, bus.mem_we); end
        n_cmp++; if (bus.mem_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb: got %b want 1100", bus.mem_wstrb); end
        n_cmp++; if (bus.mem_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want beefbeef", bus.mem_wdata); end
        n_cmp++; if (bus.mem_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL sh_addr: got %h want 00002000", bus.mem_addr); end
        bus.mem_ack = 1'b1;
        next_cycle();
        bus.mem_ack = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL sh_done: got %0b want 1", done); end
        n_cmp++; if (wb_enabled !== 1'b0 || wb_value !== 32'h0000_2002) begin n_fail++; $display("FAIL sh_wb: got en=%0b val=%h want 0 00002002", wb_enabled, wb_value); end
        next_cycle();
    endtask

    task automatic test_store_byte_word();
        instructions ins;
        ins = '0;
        ins.sb = 1'b1;
        drive_start(ins, 32'h0000_4003, 32'h1234_56A5, 1'b0, 1'b1, 1'b0, 5'd0);
        n_cmp++; if (bus.mem_wstrb !== 4'b1000 || bus.mem_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_enc: got %b/%h want 1000/a5a5a5a5", bus.mem_wstrb, bus.mem_wdata); end
        bus.mem_ack = 1'b1;
        next_cycle();
        bus.mem_ack = 1'b0;
        next_cycle();
        ins = '0;
        ins.sw = 1'b1;
        drive_start(ins, 32'h0000_4008, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 5'd0);
        n_cmp++; if (bus.mem_wstrb !== 4'b1111 || bus.mem_wdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL sw_enc: got %b/%h want 1111/0badf00d", bus.mem_wstrb, bus.mem_wdata); end
        bus.mem_ack = 1'b1;
        next_cycle();
        bus.mem_ack = 1'b0;
        next_cycle();
    endtask

    task automatic test_misaligned();
        instructions ins;
        ins = '0;
        ins.lw = 1'b1;
        drive_start(ins, 32'h0000_3001, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7);
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req: got %0b want 0", bus.mem_req); end
        n_cmp++; if (done !== 1'b1 || misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_flags: got done=%0b mis=%0b want 1 1", done, misaligned); end
        n_cmp++; if (wb_enabled !== 1'b0) begin n_fail++; $display("FAIL mis_wb_en: got %0b want 0", wb_enabled); end
        next_cycle();
        n_cmp++; if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mis_after: got req=%0b busy=%0b want 0 0", bus.mem_req, busy); end
    endtask

    task automatic test_reset_mid_req();
        instructions ins;
        ins = '0;
        ins.sw = 1'b1;
        drive_start(ins, 32'h0000_5000, 32'h5555_AAAA, 1'b0, 1'b1, 1'b0, 5'd0);
        n_cmp++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rmr_pending: got %0b want 1", bus.mem_req); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rmr_async: got req=%0b busy=%0b done=%0b want 0 0 0", bus.mem_req, busy, done); end
        next_cycle();
        rstn = 1'b1;
        next_cycle();
        ins = '0;
        ins.lw = 1'b1;
        drive_start(ins, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_BABE;
        next_cycle();
        bus.mem_ack   = 1'b0;
        n_cmp++; if (done !== 1'b1 || wb_value !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL rmr_lw: got done=%0b val=%h want 1 cafebabe", done, wb_value); end
        next_cycle();
    endtask

    task automatic test_protocol();
        instructions ins;
        bus.mem_ack = 1'b1;
        next_cycle();
        next_cycle();
        n_cmp++; if (busy !== 1'b0 || bus.mem_req !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL spur_ack: got busy=%0b req=%0b done=%0b want 0 0 0", busy, bus.mem_req, done); end
        bus.mem_ack = 1'b0;
        ins = '0;
        ins.lhu = 1'b1;
        drive_start(ins, 32'h0000_6002, 32'h0, 1'b1, 1'b0, 1'b1, 5'd12);
        result = 32'h0000_0099;
        rd_en  = 1'b0;
        dest   = 5'd20;
        start  = 1'b1;
        next_cycle();
        start  = 1'b0;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_6000) begin n_fail++; $display("FAIL req_start: got req=%0b addr=%h want 1 00006000", bus.mem_req, bus.mem_addr); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h8001_7FFF;
        next_cycle();
        bus.mem_ack   = 1'b0;
        n_cmp++; if (done !== 1'b1 || wb_value !== 32'h0000_8001 || wb_dest !== 5'd12) begin n_fail++; $display("FAIL req_start_wb: got done=%0b val=%h dest=%0d want 1 00008001 12", done, wb_value, wb_dest); end
        next_cycle();
        ins = '0;
        ins.sw = 1'b1;
        drive_start(ins, 32'h0000_7000, 32'h1122_3344, 1'b1, 1'b1, 1'b1, 5'd4);
        n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_wstrb !== 4'b1111 || bus.mem_wdata !== 32'h1122_3344) begin n_fail++; $display("FAIL rw_both: got we=%0b strb=%b data=%h want 1 1111 11223344", bus.mem_we, bus.mem_wstrb, bus.mem_wdata); end
        bus.mem_ack = 1'b1;
        next_cycle();
        bus.mem_ack = 1'b0;
        n_cmp++; if (wb_enabled !== 1'b0 || wb_value !== 32'h0000_7000) begin n_fail++; $display("FAIL rw_both_wb: got en=%0b val=%h want 0 00007000", wb_enabled, wb_value); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        instructions ins;
        drive_start('0, 32'h0000_00AA, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2);
        result = 32'h0000_00BB;
        start  = 1'b1;
        next_cycle();
        start  = 1'b0;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || wb_value !== 32'h0000_00AA) begin n_fail++; $display("FAIL b2b_ignored: got done=%0b busy=%0b val=%h want 0 0 000000aa", done, busy, wb_value); end
        ins = '0;
        ins.lh = 1'b1;
        drive_start(ins, 32'h0000_8000, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_8001;
        next_cycle();
        bus.mem_ack   = 1'b0;
        n_cmp++; if (done !== 1'b1 || wb_value !== 32'hFFFF_8001) begin n_fail++; $display("FAIL b2b_lh: got done=%0b val=%h want 1 ffff8001", done, wb_value); end
        next_cycle();
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        test_reset();
        test_pass_through();
        test_load_byte(1'b0, 32'hFFFF_FF80);
        test_load_byte(1'b1, 32'h0000_0080);
        test_store_half();
        test_store_byte_word();
        test_misaligned();
        test_reset_mid_req();
        test_protocol();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
